truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Synthesizable on-board counterpart of the simulation stimulus bench for the two-input `top` logic block.
- Drives `in_1`/`in_0` through the four input vectors, in the same order the bench applies them: 00, 10, 01, 11 (written as in_1,in_0).
- Samples the block's `out_0` after a settle window and compares it against an expected truth table.
- Reports pass/fail and a per-vector mismatch mask, so the gate is self-tested on the TinyFPGA board without a simulator.

Parameters:
- EXPECTED, 4'b1000: expected out_0 per vector; bit index = {in_1,in_0}. Default is AND.
- SETTLE_CYCLES, 16: clock cycles each vector is held before sampling. Must be >= 3, to cover the 2-flop synchronizer plus the DUT.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- dut_out  input  1  out_0 of the block under test; asynchronous to CLK.
- in_1_drv  output  1  drives in_1 of the block under test.
- in_0_drv  output  1  drives in_0 of the block under test.
- busy  output  1  high while vectors are being applied.
- done  output  1  high in DONE until the next accepted start or RST.
- pass  output  1  valid when done=1; pass = (mismatch_mask == 0).
- fail_step  output  2  lowest failing step index (0..3); 0 when pass=1.
- mismatch_mask  output  4  bit k set if step k failed.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST; RST has priority over all other inputs.
- Reset values: state=IDLE, step=0, cnt=0, synchronizer flops=0. All outputs 0.
- Synchronizer: dut_out passes through 2 flops to give dut_s; only dut_s is compared.
- Step-to-vector mapping: for step k, in_1_drv=k[0] and in_0_drv=k[1]. Steps run 0,1,2,3, giving vectors 00,10,01,11.
- Expected value for step k: EXPECTED[{k[0],k[1]}].
- IDLE state:
  - Drives=00, busy=0, done=0.
  - If start=1 in cycle t: at t+1 go to RUN with step=0, cnt=0, mismatch_mask cleared, busy=1.
- RUN state:
  - Drives reflect the current step.
  - cnt increments every cycle.
  - When cnt == SETTLE_CYCLES-1: compare dut_s to the expected bit and set mismatch_mask[step] on mismatch.
  - In that same cycle: if step<3, the next cycle has step+1 and cnt=0; if step==3, the next cycle is DONE.
- RUN timing:
  - Each vector is held exactly SETTLE_CYCLES cycles.
  - The sample is taken in the last cycle of each hold.
  - The drive change and the sample are never in the same cycle.
- DONE state:
  - Entered at cycle t+1+4*SETTLE_CYCLES: done=1, busy=0, drives=00.
  - pass, mismatch_mask and fail_step are held stable.
  - fail_step = index of the lowest set bit of mismatch_mask, else 0.
- start in DONE: treated exactly as in IDLE, i.e. RUN at the next cycle. done drops, mask clears.
- start during RUN: ignored. Not queued, no effect on the step or the counter.
- RST mid-RUN: next cycle is IDLE with drives=00, mask=0, done=0. A partial result is never reported.
- Counter width: ceil(log2(SETTLE_CYCLES)) bits. No wrap can occur, because cnt resets at SETTLE_CYCLES-1.
- State encoding: free choice. No illegal-state lockup; any undefined state returns to IDLE.

Test Plan:
- Default AND model on dut_out (combinational from the drives), start pulse at t=10 -> busy high t=11..74, done=1 and pass=1 at t=75, mask=0000, fail_step=0.
- dut_out stuck at 0 -> mask=1000 (step 3, vector 11, fails), fail_step=3, pass=0.
- dut_out = NOT(AND) -> mask=1111, fail_step=0, pass=0. Drive sequence observed as 00,10,01,11, each held 16 cycles.
- SETTLE_CYCLES=3 with a 1-cycle registered DUT delay -> still pass. A start pulse held high for 5 cycles during RUN -> exactly one run, done at start+1+12.
- RST asserted for 1 cycle at step 2 -> next cycle IDLE, drives=00, mask=0, done=0. A new start then runs the full 4*S cycles.
- From DONE with pass=0, start with a correct AND model -> done drops next cycle, mask clears, finishes with pass=1.

Source files
------------

// File: rtl/truth_table_checker.sv
// Hardware self-test for a two-input gate: steps the inputs through 00,10,01,11
// (in_1,in_0), samples the synchronized gate output after a settle window, and reports a mismatch mask.
module truth_table_checker #(
    parameter logic [3:0] EXPECTED      = 4'b1000,
    parameter int         SETTLE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       dut_out,
    output logic       in_1_drv,
    output logic       in_0_drv,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_step,
    output logic [3:0] mismatch_mask
);

    localparam int              CW       = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_step,  w_step_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [3:0]      r_mask,  w_mask_nxt;
    logic            r_sync1, r_sync2;
    logic            w_last;
    logic            w_exp_bit;
    logic [1:0]      w_fail;

    assign w_last    = (r_cnt == CNT_LAST);
    // Step k drives in_1=k[0], in_0=k[1], so the truth-table index is {k[0],k[1]}.
    assign w_exp_bit = EXPECTED[{r_step[0], r_step[1]}];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_step  <= 2'd0;
            r_cnt   <= '0;
            r_mask  <= 4'd0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_step_nxt  = 2'd0;
                    w_cnt_nxt   = '0;
                    w_mask_nxt  = 4'd0;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    if (r_sync2 != w_exp_bit) begin
                        w_mask_nxt[r_step] = 1'b1;
                    end
                    w_cnt_nxt = '0;
                    if (r_step == 2'd3) begin
                        w_state_nxt = ST_DONE;
                        w_step_nxt  = 2'd0;
                    end else begin
                        w_step_nxt = r_step + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = 2'd0;
                w_cnt_nxt   = '0;
                w_mask_nxt  = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_fail = 2'd0;
        if (r_mask[0])      w_fail = 2'd0;
        else if (r_mask[1]) w_fail = 2'd1;
        else if (r_mask[2]) w_fail = 2'd2;
        else if (r_mask[3]) w_fail = 2'd3;
    end

    assign busy          = (r_state == ST_RUN);
    assign done          = (r_state == ST_DONE);
    assign in_1_drv      = busy & r_step[0];
    assign in_0_drv      = busy & r_step[1];
    assign pass          = done & (r_mask == 4'd0);
    assign fail_step     = w_fail;
    assign mismatch_mask = r_mask;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: fake gate driven from a 4-bit truth table,
// table vectors plus random gates checked against a step/vector reference model.
module tb_truth_table_checker;

    localparam int S  = 16;
    localparam int S3 = 3;
    localparam logic [3:0] EXP_TT = 4'b1000;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, start, start3;
    logic [3:0] tt, tt3;
    logic       dut_out, dut_out3;
    logic       in_1_drv, in_0_drv, busy, done, pass;
    logic [1:0] fail_step;
    logic [3:0] mismatch_mask;
    logic       in_1_drv3, in_0_drv3, busy3, done3, pass3;
    logic [1:0] fail_step3;
    logic [3:0] mismatch_mask3;

    // Gate under test modelled as a truth table indexed by {in_1,in_0}.
    assign dut_out = tt[{in_1_drv, in_0_drv}];
    // Second gate has one register stage of output latency.
    always @(negedge CLK) dut_out3 <= tt3[{in_1_drv3, in_0_drv3}];

    truth_table_checker #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(S)) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .dut_out(dut_out),
        .in_1_drv(in_1_drv), .in_0_drv(in_0_drv), .busy(busy), .done(done),
        .pass(pass), .fail_step(fail_step), .mismatch_mask(mismatch_mask)
    );

    truth_table_checker #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(S3)) u_dut3 (
        .CLK(CLK), .RST(RST), .start(start3), .dut_out(dut_out3),
        .in_1_drv(in_1_drv3), .in_0_drv(in_0_drv3), .busy(busy3), .done(done3),
        .pass(pass3), .fail_step(fail_step3), .mismatch_mask(mismatch_mask3)
    );

    int checks   = 0;
    int failures = 0;

    // Vector applied at step k, as {in_1,in_0}.
    logic [1:0] vec_tbl [4];

    typedef struct {
        string      name;
        logic [3:0] f;
        logic [3:0] mask;
        logic       pass;
        logic [1:0] fail;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] ref_mask(input logic [3:0] f);
        logic [3:0] m;
        m = 4'd0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx  = 2 * vec_tbl[k][1] + vec_tbl[k][0];
            m[k] = (f[idx] != EXP_TT[idx]);
        end
        return m;
    endfunction

    function automatic logic [1:0] ref_fail(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) if (m[k]) r = 2'(k);
        return r;
    endfunction

    // Full run on the S=16 instance: start pulse, per-cycle busy/drive check, final result.
    task automatic run_main(input string name, input logic [3:0] f, input logic [3:0] exp_mask,
                            input logic exp_pass, input logic [1:0] exp_fail);
        int bad_busy, bad_drv;
        bad_busy = 0;
        bad_drv  = 0;
        tt    = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_start_done_low"}, 32'(done), 32'd0);
        check({name, "_start_mask_clr"}, 32'(mismatch_mask), 32'd0);
        for (int i = 0; i < 4 * S; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            if ({in_1_drv, in_0_drv} !== vec_tbl[i / S]) bad_drv++;
            tick();
        end
        check({name, "_busy_window"}, 32'(bad_busy), 32'd0);
        check({name, "_drive_seq"}, 32'(bad_drv), 32'd0);
        check({name, "_done"}, {30'd0, done, busy}, 32'b10);
        check({name, "_drv_idle"}, {30'd0, in_1_drv, in_0_drv}, 32'd0);
        check({name, "_mask"}, 32'(mismatch_mask), 32'(exp_mask));
        check({name, "_pass"}, 32'(pass), 32'(exp_pass));
        check({name, "_fail_step"}, 32'(fail_step), 32'(exp_fail));
    endtask

    initial begin
        vec_tbl[0] = 2'b00; vec_tbl[1] = 2'b10; vec_tbl[2] = 2'b01; vec_tbl[3] = 2'b11;
        tbl[0] = '{"and",     4'b1000, 4'b0000, 1'b1, 2'd0};
        tbl[1] = '{"stuck0",  4'b0000, 4'b1000, 1'b0, 2'd3};
        tbl[2] = '{"nand",    4'b0111, 4'b1111, 1'b0, 2'd0};
        tbl[3] = '{"and_rec", 4'b1000, 4'b0000, 1'b1, 2'd0};
        tbl[4] = '{"stuck1",  4'b1111, 4'b0111, 1'b0, 2'd0};
        tbl[5] = '{"or",      4'b1110, 4'b0110, 1'b0, 2'd1};
        tbl[6] = '{"xor",     4'b0110, 4'b1110, 1'b0, 2'd1};
        tbl[7] = '{"in0",     4'b1010, 4'b0100, 1'b0, 2'd2};

        RST = 1'b1; start = 1'b0; start3 = 1'b0; tt = 4'b1000; tt3 = 4'b1000;
        repeat (3) tick();
        check("rst_outputs", {in_1_drv, in_0_drv, busy, done, pass, fail_step, mismatch_mask}, 32'd0);
        check("rst_outputs3", {in_1_drv3, in_0_drv3, busy3, done3, pass3, fail_step3, mismatch_mask3}, 32'd0);
        RST = 1'b0;
        repeat (2) tick();
        check("idle_no_start", {30'd0, busy, done}, 32'd0);

        foreach (tbl[i]) run_main(tbl[i].name, tbl[i].f, tbl[i].mask, tbl[i].pass, tbl[i].fail);

        repeat (6) begin
            logic [3:0] f, m;
            f = 4'($urandom_range(0, 15));
            m = ref_mask(f);
            run_main("rand", f, m, (m == 4'd0), ref_fail(m));
        end

        // Reset in the middle of step 2 with a failing gate.
        tt    = 4'b0111;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 * S + 5) tick();
        check("mid_step2", {28'd0, in_1_drv, in_0_drv, busy, 1'b0}, {28'd0, 2'b01, 1'b1, 1'b0});
        check("mid_partial_mask", 32'(mismatch_mask), 32'b0011);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid_run", {in_1_drv, in_0_drv, busy, done, pass, mismatch_mask}, 32'd0);
        repeat (3) tick();
        check("rst_stays_idle", {30'd0, busy, done}, 32'd0);
        run_main("after_rst", 4'b1000, 4'b0000, 1'b1, 2'd0);

        // S=3 instance with registered gate; start held 5 cycles must give one run.
        begin
            int bad;
            bad    = 0;
            start3 = 1'b1;
            for (int c = 1; c <= 4 * S3; c++) begin
                tick();
                if (c == 5) start3 = 1'b0;
                if (busy3 !== 1'b1 || done3 !== 1'b0) bad++;
            end
            check("s3_busy_window", 32'(bad), 32'd0);
            tick();
            check("s3_done_time", {30'd0, done3, busy3}, 32'b10);
            check("s3_pass", {27'd0, pass3, mismatch_mask3}, {27'd0, 1'b1, 4'b0000});
            repeat (4) tick();
            check("s3_single_run", {30'd0, done3, busy3}, 32'b10);
        end

        begin
            tt3    = 4'b0110;
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            repeat (4 * S3) tick();
            check("s3_xor_done", 32'(done3), 32'd1);
            check("s3_xor_mask", 32'(mismatch_mask3), 32'(ref_mask(4'b0110)));
            check("s3_xor_fail", {29'd0, pass3, fail_step3}, {29'd0, 1'b0, ref_fail(ref_mask(4'b0110))});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
